// File: rtl/npc_difftest_pkg.sv
// Shared types and sizes for the difftest state-transfer blocks.
// Covers the GPR/pc restore path from the host into the core.
package npc_difftest_pkg;

    localparam int XLEN   = 64;
    localparam int NREGS  = 33;
    localparam int PC_IDX = 32;
    localparam int IDX_W  = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } restore_state_e;

    typedef logic [4:0]       gpr_idx_t;
    typedef logic [IDX_W-1:0] restore_idx_t;

endpackage

// File: rtl/gpr_restore.sv
// Streams x0..x31 and pc from the host into the core, one word per handshake,
// keeping the core stalled until the last word has been written.
module gpr_restore
    import npc_difftest_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_data,
    output logic            in_ready,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            pc_wen,
    output logic [XLEN-1:0] pc_wdata,
    output logic            core_stall,
    output logic            busy,
    output logic            done,
    output logic            err_x0
);

    restore_state_e  state_q, state_d;
    restore_idx_t    idx_q, idx_d;
    logic            err_q, err_d;
    logic            rf_wen_q, rf_wen_d;
    gpr_idx_t        rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            pc_wen_q, pc_wen_d;
    logic [XLEN-1:0] pc_wdata_q, pc_wdata_d;

    logic hs;
    logic last_word;

    assign hs        = in_valid && (state_q == LOAD);
    assign last_word = (idx_q == restore_idx_t'(PC_IDX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            err_q      <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pc_wen_q   <= 1'b0;
            pc_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pc_wen_q   <= pc_wen_d;
            pc_wdata_q <= pc_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = LOAD;
            LOAD:    if (hs && last_word) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write ports pulse for one cycle; data holds its last value otherwise.
    always_comb begin
        idx_d      = idx_q;
        err_d      = err_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        pc_wen_d   = 1'b0;
        pc_wdata_d = pc_wdata_q;
        if (state_q == IDLE && start_i) begin
            idx_d = '0;
            err_d = 1'b0;
        end
        if (hs) begin
            if (!last_word) begin
                idx_d = idx_q + restore_idx_t'(1);
            end
            if (idx_q == '0) begin
                if (in_data != '0) err_d = 1'b1;
            end else if (last_word) begin
                pc_wen_d   = 1'b1;
                pc_wdata_d = in_data;
            end else begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = idx_q[4:0];
                rf_wdata_d = in_data;
            end
        end
    end

    always_comb begin
        in_ready   = (state_q == LOAD);
        busy       = (state_q != IDLE);
        core_stall = (state_q != IDLE);
        done       = (state_q == FINISH);
        err_x0     = err_q;
        rf_wen     = rf_wen_q;
        rf_waddr   = rf_waddr_q;
        rf_wdata   = rf_wdata_q;
        pc_wen     = pc_wen_q;
        pc_wdata   = pc_wdata_q;
    end

endmodule

// File: tb/tb_gpr_restore.sv
// Self-checking bench for gpr_restore: scenario table, corner sequences,
// and a write log compared against the word stream each restore sends.
module tb_gpr_restore;
    import npc_difftest_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic            in_valid = 1'b0;
    logic [XLEN-1:0] in_data = '0;
    logic            in_ready;
    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            pc_wen;
    logic [XLEN-1:0] pc_wdata;
    logic            core_stall;
    logic            busy;
    logic            done;
    logic            err_x0;

    gpr_restore dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc_wen(pc_wen), .pc_wdata(pc_wdata),
        .core_stall(core_stall), .busy(busy), .done(done),
        .err_x0(err_x0)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;

    wr_t         rf_log[$];
    logic [63:0] pc_log[$];
    int          done_cnt = 0;
    bit          in_load = 1'b0;

    // Write observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (rf_wen) rf_log.push_back('{rf_waddr, rf_wdata});
        if (pc_wen) pc_log.push_back(pc_wdata);
        if (done) done_cnt++;
        if (rf_wen) begin
            check("one_port", {63'b0, pc_wen}, 64'd0);
            check("waddr_nz", {63'b0, rf_waddr == 5'd0}, 64'd0);
        end
    end

    typedef struct {
        logic [63:0] x0;
        bit          basic;
        int          density;
        int          pulse_idx;
        bit          exp_err;
        bit          hold_start;
    } vec_t;

    task automatic run_restore(input vec_t v);
        logic [63:0] words[NREGS];
        int          idx;
        int          cyc;
        bit          vld;
        for (int i = 0; i < NREGS; i++) begin
            if (v.basic)
                words[i] = (i == PC_IDX) ? 64'h8000_0000 : 64'(i) * 16 + 1;
            else
                words[i] = {$urandom, $urandom};
        end
        words[0] = v.x0;
        rf_log.delete();
        pc_log.delete();
        done_cnt = 0;
        if (!in_load) begin
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        in_load = 1'b0;
        check("stall_on", {62'b0, core_stall, busy}, 64'd3);
        check("ready_on", in_ready, 1);
        check("err_clr", err_x0, 0);
        idx = 0;
        cyc = 0;
        while (idx < NREGS && cyc < 2000) begin
            vld = ($urandom_range(99) < v.density);
            in_valid = vld;
            in_data = vld ? words[idx] : {$urandom, $urandom};
            start_i = (idx == v.pulse_idx);
            @(posedge clk); #1;
            cyc++;
            if (vld) idx++;
            if (idx < NREGS) begin
                check("ready_load", in_ready, 1);
                check("busy_load", {62'b0, core_stall, busy}, 64'd3);
                check("no_done", {62'b0, done, pc_wen}, 64'd0);
            end
        end
        check("words_accepted", idx, NREGS);
        in_valid = 1'b0;
        start_i = v.hold_start;
        check("done_T1", done, 1);
        check("pc_wen_T1", pc_wen, 1);
        check("pc_wdata", pc_wdata, words[PC_IDX]);
        check("ready_fin", in_ready, 0);
        check("busy_fin", {62'b0, core_stall, busy}, 64'd3);
        check("rf_wen_fin", rf_wen, 0);
        check("err_x0", err_x0, v.exp_err);
        @(posedge clk); #1;
        check("stall_off_T2", {62'b0, core_stall, busy}, 64'd0);
        check("done_off_T2", done, 0);
        check("rf_count", rf_log.size(), 31);
        for (int i = 0; i < rf_log.size() && i < 31; i++) begin
            check("rf_addr", rf_log[i].a, i + 1);
            check("rf_data", rf_log[i].d, words[i+1]);
        end
        check("pc_count", pc_log.size(), 1);
        check("done_count", done_cnt, 1);
        if (v.hold_start) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            check("restart_busy", busy, 1);
            check("restart_ready", in_ready, 1);
            in_load = 1'b1;
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{64'h0,    1'b1, 100, -1, 1'b0, 1'b0};
        vecs[1] = '{64'h0,    1'b0,  50, -1, 1'b0, 1'b0};
        vecs[2] = '{64'hDEAD, 1'b0, 100, -1, 1'b1, 1'b0};
        vecs[3] = '{64'h0,    1'b0, 100, 10, 1'b0, 1'b1};
        vecs[4] = '{64'h1,    1'b0,  40, 32, 1'b1, 1'b0};
        vecs[5] = '{64'h0,    1'b0,  70,  0, 1'b0, 1'b0};

        #2;
        check("rst_ctl",
              {55'b0, in_ready, rf_wen, rf_waddr, pc_wen},
              64'd0);
        check("rst_sts", {60'b0, core_stall, busy, done, err_x0}, 64'd0);
        check("rst_rfd", rf_wdata, 0);
        check("rst_pcd", pc_wdata, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        rf_log.delete();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = {$urandom, $urandom};
            @(posedge clk); #1;
            check("idle_ready", in_ready, 0);
            check("idle_stall", {62'b0, core_stall, busy}, 64'd0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_writes", rf_log.size() + pc_log.size(), 0);

        for (int k = 0; k < 6; k++) run_restore(vecs[k]);

        done_cnt = 0;
        pc_log.delete();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_data = {$urandom, $urandom} | 64'h1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl",
              {55'b0, in_ready, rf_wen, rf_waddr, pc_wen},
              64'd0);
        check("mid_rst_sts",
              {60'b0, core_stall, busy, done, err_x0}, 64'd0);
        check("mid_rst_rfd", rf_wdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("mid_rst_done", done_cnt, 0);
        check("mid_rst_pc", pc_log.size(), 0);
        @(posedge clk); #1;
        run_restore('{64'h0, 1'b0, 100, -1, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
